// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_pkg                                                             |
// | Shared types for the write-back/commit stage and its commit queue. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package wb_pkg;

    localparam int ECODE_W      = 6;
    localparam int ESUBCODE_W   = 9;
    localparam int WB_DATA_W    = 32;
    localparam int WB_CSR_NUM_W = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CSR_RD = 2'd1,
        CSR_WB = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                    gr_we;
        logic [4:0]              dest;
        logic [WB_DATA_W-1:0]    pc;
        logic [WB_DATA_W-1:0]    result;
        logic                    csr_we;
        logic                    csr_re;
        logic [WB_CSR_NUM_W-1:0] csr_num;
        logic [WB_DATA_W-1:0]    csr_wmask;
        logic [WB_DATA_W-1:0]    csr_wvalue;
        logic                    ertn;
        logic                    ex;
        logic [ECODE_W-1:0]      ecode;
        logic [ESUBCODE_W-1:0]   esubcode;
        logic [WB_DATA_W-1:0]    vaddr;
    } wb_entry_t;

    function automatic logic is_csr_access(input wb_entry_t e);
        return e.csr_re | e.csr_we;
    endfunction

    // Entries that ID must not read CSRs past: CSR accessors and ertn.
    function automatic logic holds_csr_dep(input wb_entry_t e);
        return e.csr_re | e.csr_we | e.ertn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_commit_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_commit_fifo                                                     |
// | In-order DEPTH-entry commit queue with push, pop and flush.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_commit_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  wb_entry_t              din,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_commit_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_commit_stage                                                    |
// | LoongArch WB/commit: commit queue, 2-cycle CSR commit, ex/ertn     |
// | flush. Define WB_TRACE_EN to add the debug_wb_* trace ports.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int DATA_W    = 32,
    parameter int CSR_NUM_W = 14
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_wb_valid,
    output logic                  wb_allowin,
    input  logic                  mem_gr_we,
    input  logic [4:0]            mem_dest,
    input  logic [DATA_W-1:0]     mem_pc,
    input  logic [DATA_W-1:0]     mem_result,
    input  logic                  mem_csr_we,
    input  logic                  mem_csr_re,
    input  logic [CSR_NUM_W-1:0]  mem_csr_num,
    input  logic [DATA_W-1:0]     mem_csr_wmask,
    input  logic [DATA_W-1:0]     mem_csr_wvalue,
    input  logic                  mem_ertn,
    input  logic                  mem_ex,
    input  logic [ECODE_W-1:0]    mem_ecode,
    input  logic [ESUBCODE_W-1:0] mem_esubcode,
    input  logic [DATA_W-1:0]     mem_vaddr,
    output logic [CSR_NUM_W-1:0]  csr_num,
    output logic                  csr_re,
    input  logic [DATA_W-1:0]     csr_rvalue,
    output logic                  csr_we,
    output logic [DATA_W-1:0]     csr_wmask,
    output logic [DATA_W-1:0]     csr_wvalue,
    output logic                  wb_ex,
    output logic                  ertn_flush,
    output logic [DATA_W-1:0]     wb_pc,
    output logic [DATA_W-1:0]     wb_vaddr,
    output logic [ECODE_W-1:0]    wb_ecode,
    output logic [ESUBCODE_W-1:0] wb_esubcode,
`ifdef WB_TRACE_EN
    output logic [DATA_W-1:0]     debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [DATA_W-1:0]     debug_wb_rf_wdata,
`endif
    output logic [38:0]           wb_id_bus
);

    // count spans 0..DEPTH inclusive, hence one bit wider than the pointers.
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        in_entry;
    wb_entry_t        head;
    logic [CNT_W-1:0] count;
    logic             head_valid;
    logic             push;
    logic             retire;
    logic             flush;
    logic             use_csr_data;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             csr_pending;
    wb_state_t        state_q, state_d, phase;
    logic [CNT_W-1:0] dep_cnt_q, dep_cnt_d;

    always_comb begin
        in_entry = '{gr_we:      mem_gr_we,
                     dest:       mem_dest,
                     pc:         mem_pc,
                     result:     mem_result,
                     csr_we:     mem_csr_we,
                     csr_re:     mem_csr_re,
                     csr_num:    mem_csr_num,
                     csr_wmask:  mem_csr_wmask,
                     csr_wvalue: mem_csr_wvalue,
                     ertn:       mem_ertn,
                     ex:         mem_ex,
                     ecode:      mem_ecode,
                     esubcode:   mem_esubcode,
                     vaddr:      mem_vaddr};
    end

    wb_commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (retire),
        .flush  (flush),
        .din    (in_entry),
        .head   (head),
        .count  (count)
    );

    assign head_valid = (count != '0);
    assign flush      = wb_ex | ertn_flush;
    assign wb_allowin = ((count != FULL_CNT) | retire) & ~flush;
    assign push       = mem_wb_valid & wb_allowin;

    // A CSR head sitting in IDLE is in its read phase; the state register only
    // records the following write-back cycle.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && is_csr_access(head)) begin
            phase = CSR_RD;
        end
        state_d      = state_q;
        retire       = 1'b0;
        use_csr_data = 1'b0;
        wb_ex        = 1'b0;
        ertn_flush   = 1'b0;
        csr_re       = 1'b0;
        csr_we       = 1'b0;
        if (!head_valid) begin
            state_d = IDLE;
        end else if (head.ex) begin
            wb_ex   = 1'b1;
            state_d = IDLE;
        end else if (head.ertn) begin
            ertn_flush = 1'b1;
            state_d    = IDLE;
        end else begin
            case (phase)
                CSR_RD: begin
                    csr_re  = 1'b1;
                    state_d = CSR_WB;
                end
                CSR_WB: begin
                    retire       = 1'b1;
                    use_csr_data = 1'b1;
                    csr_we       = head.csr_we;
                    state_d      = IDLE;
                end
                default: retire = 1'b1;
            endcase
        end
    end

    always_comb begin
        dep_cnt_d = dep_cnt_q;
        if (flush) begin
            dep_cnt_d = '0;
        end else begin
            if (push && holds_csr_dep(in_entry)) begin
                dep_cnt_d = dep_cnt_d + CNT_W'(1);
            end
            if (retire && holds_csr_dep(head)) begin
                dep_cnt_d = dep_cnt_d - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            dep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dep_cnt_q <= dep_cnt_d;
        end
    end

    assign csr_pending = (dep_cnt_q != '0);
    assign rf_we       = retire & head.gr_we;
    assign rf_waddr    = rf_we ? head.dest : 5'd0;
    assign rf_wdata    = !rf_we       ? 32'd0 :
                         use_csr_data ? csr_rvalue : head.result;
    assign wb_id_bus   = {rf_we, rf_waddr, rf_wdata, csr_pending};

    assign csr_num     = (csr_re | csr_we) ? head.csr_num : '0;
    assign csr_wmask   = csr_we ? head.csr_wmask  : '0;
    assign csr_wvalue  = csr_we ? head.csr_wvalue : '0;
    assign wb_pc       = wb_ex ? head.pc       : '0;
    assign wb_vaddr    = wb_ex ? head.vaddr    : '0;
    assign wb_ecode    = wb_ex ? head.ecode    : '0;
    assign wb_esubcode = wb_ex ? head.esubcode : '0;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = retire ? head.pc : '0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule
`default_nettype wire
